stack_unit: RTL and testbench

STACK_UNIT -- requirements
Module: stack_unit

---
 rtl/stack_unit.sv | 140 ++++++++++++++
 tb/tb_stack_unit.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/stack_unit.sv
// rtl/stack_unit.sv - hardware stack engine: multi-byte push/pull against a paged stack in memory
//
// Ports:
//   clk, resetn          clock and synchronous active-low reset
//   start, op, count     transaction request (op 0 = push, 1 = pull), count bytes 1..MAX_BYTES
//   push_data            bytes to push, byte 0 in the low lane and pushed first
//   sp_load, sp_load_val load S directly (TXS), only honoured in IDLE
//   rd_data              memory read data, valid the cycle after address
//   address, wr_data,    registered memory interface
//   wr_enable
//   busy, done           transaction in progress / one-cycle completion pulse
//   pull_data            pulled bytes, byte i is the i-th byte pulled
//   sp, sp_wrap          current S and sticky wrap flag for the current/last transaction
module stack_unit #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 16,
    parameter int SP_W = 8,
    parameter logic [ADDR_W-1:0] STACK_PAGE = 16'h0100,
    parameter int MAX_BYTES = 3,
    localparam int CNT_W = $clog2(MAX_BYTES + 1)
) (
    input  logic                          clk,
    input  logic                          resetn,
    input  logic                          start,
    input  logic                          op,
    input  logic [CNT_W-1:0]              count,
    input  logic [MAX_BYTES*DATA_W-1:0]   push_data,
    input  logic                          sp_load,
    input  logic [SP_W-1:0]               sp_load_val,
    input  logic [DATA_W-1:0]             rd_data,
    output logic [ADDR_W-1:0]             address,
    output logic [DATA_W-1:0]             wr_data,
    output logic                          wr_enable,
    output logic                          busy,
    output logic                          done,
    output logic [MAX_BYTES*DATA_W-1:0]   pull_data,
    output logic [SP_W-1:0]               sp,
    output logic                          sp_wrap
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_PUSH = 2'd1;
    localparam logic [1:0] ST_PULL = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_BYTES);
    localparam logic [CNT_W-1:0] ONE_CNT = CNT_W'(1);

    logic [1:0]                state;
    logic [SP_W-1:0]           s;
    logic [CNT_W-1:0]          idx;      // number of bytes already issued
    logic [CNT_W-1:0]          cnt_q;
    logic [MAX_BYTES*DATA_W-1:0] push_q;

    logic [SP_W-1:0] s_dec;
    logic [SP_W-1:0] s_inc;
    logic            start_ok;

    assign s_dec    = s - 1'b1;
    assign s_inc    = s + 1'b1;
    assign start_ok = start && !sp_load && (count != '0) && (count <= MAX_CNT);

    assign busy = (state != ST_IDLE);
    assign done = (state == ST_DONE);
    assign sp   = s;

    function automatic logic [ADDR_W-1:0] stack_addr(input logic [SP_W-1:0] v);
        return STACK_PAGE | {{(ADDR_W-SP_W){1'b0}}, v};
    endfunction

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state     <= ST_IDLE;
            s         <= '1;
            idx       <= '0;
            cnt_q     <= '0;
            push_q    <= '0;
            address   <= '0;
            wr_data   <= '0;
            wr_enable <= 1'b0;
            pull_data <= '0;
            sp_wrap   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (sp_load) begin
                        s <= sp_load_val;
                    end else if (start_ok) begin
                        // The accepting edge already issues the first access.
                        cnt_q     <= count;
                        push_q    <= push_data;
                        pull_data <= '0;
                        idx       <= ONE_CNT;
                        if (!op) begin
                            address   <= stack_addr(s);
                            wr_data   <= push_data[DATA_W-1:0];
                            wr_enable <= 1'b1;
                            s         <= s_dec;
                            sp_wrap   <= (s == '0);
                            state     <= ST_PUSH;
                        end else begin
                            address   <= stack_addr(s_inc);
                            s         <= s_inc;
                            sp_wrap   <= (s == '1);
                            state     <= ST_PULL;
                        end
                    end
                end
                ST_PUSH: begin
                    if (idx < cnt_q) begin
                        address <= stack_addr(s);
                        wr_data <= push_q[int'(idx)*DATA_W +: DATA_W];
                        s       <= s_dec;
                        idx     <= idx + ONE_CNT;
                        if (s == '0) sp_wrap <= 1'b1;
                    end else begin
                        wr_enable <= 1'b0;
                        state     <= ST_DONE;
                    end
                end
                ST_PULL: begin
                    // Data for the previously issued address arrives now.
                    pull_data[(int'(idx)-1)*DATA_W +: DATA_W] <= rd_data;
                    if (idx < cnt_q) begin
                        address <= stack_addr(s_inc);
                        s       <= s_inc;
                        idx     <= idx + ONE_CNT;
                        if (s == '1) sp_wrap <= 1'b1;
                    end else begin
                        state <= ST_DONE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_stack_unit.sv
// tb/tb_stack_unit.sv - scoreboard bench for stack_unit with a behavioural stack/memory model
module tb_stack_unit;

    logic        clk = 1'b0;
    logic        resetn;
    logic        start;
    logic        op;
    logic [1:0]  count;
    logic [23:0] push_data;
    logic        sp_load;
    logic [7:0]  sp_load_val;
    logic [7:0]  rd_data;
    logic [15:0] address;
    logic [7:0]  wr_data;
    logic        wr_enable;
    logic        busy;
    logic        done;
    logic [23:0] pull_data;
    logic [7:0]  sp;
    logic        sp_wrap;

    always #5 clk = ~clk;

    stack_unit dut (
        .clk(clk), .resetn(resetn), .start(start), .op(op), .count(count),
        .push_data(push_data), .sp_load(sp_load), .sp_load_val(sp_load_val),
        .rd_data(rd_data), .address(address), .wr_data(wr_data),
        .wr_enable(wr_enable), .busy(busy), .done(done), .pull_data(pull_data),
        .sp(sp), .sp_wrap(sp_wrap)
    );

    // Bench-side memory: unwritten locations read as a fixed address pattern.
    bit [7:0] mem [0:511];
    bit       wr_flag [0:511];

    always @(posedge clk) begin
        if (wr_enable) begin
            mem[address[8:0]]     <= wr_data;
            wr_flag[address[8:0]] <= 1'b1;
        end
    end

    assign rd_data = wr_flag[address[8:0]] ? mem[address[8:0]] : (address[7:0] ^ 8'h5A);

    int vectors = 0;
    int errors  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference model: a stack pointer and a byte memory, updated byte by byte.
    typedef struct { logic [15:0] a; logic [7:0] d; } wr_t;
    typedef struct { logic [23:0] pd; logic [7:0] sp; logic wrap; } res_t;

    wr_t      wr_q [$];
    res_t     res_q [$];
    bit [7:0] mmem [0:511];
    logic [7:0] ms;

    task automatic model_push(input int n, input logic [23:0] d, input int nw, input bit expect_res);
        logic wrap;
        logic [15:0] a;
        wrap = 1'b0;
        for (int i = 0; i < n; i++) begin
            a = 16'h0100 | {8'h00, ms};
            if (i < nw) begin
                wr_q.push_back('{a, d[i*8 +: 8]});
                mmem[a[8:0]] = d[i*8 +: 8];
            end
            if (ms == 8'h00) wrap = 1'b1;
            ms = ms - 8'd1;
        end
        if (expect_res) res_q.push_back('{24'h0, ms, wrap});
    endtask

    task automatic model_pull(input int n);
        logic wrap;
        logic [15:0] a;
        logic [23:0] pd;
        wrap = 1'b0;
        pd   = 24'h0;
        for (int i = 0; i < n; i++) begin
            if (ms == 8'hFF) wrap = 1'b1;
            ms = ms + 8'd1;
            a  = 16'h0100 | {8'h00, ms};
            pd[i*8 +: 8] = mmem[a[8:0]];
        end
        res_q.push_back('{pd, ms, wrap});
    endtask

    // Monitor: pops expectations whenever the DUT writes or signals done.
    initial begin
        wr_t  w;
        res_t r;
        forever begin
            @(negedge clk);
            if (wr_enable) begin
                if (wr_q.size() == 0) begin
                    vectors++;
                    errors++;
                    $display("FAIL unexpected_write: got addr %h data %h expected no write", address, wr_data);
                end else begin
                    w = wr_q.pop_front();
                    check("wr_addr", address, w.a);
                    check("wr_data", wr_data, w.d);
                end
            end
            if (done) begin
                if (res_q.size() == 0) begin
                    vectors++;
                    errors++;
                    $display("FAIL unexpected_done: got done=1 expected no done");
                end else begin
                    r = res_q.pop_front();
                    check("pull_data", pull_data, r.pd);
                    check("sp_at_done", sp, r.sp);
                    check("sp_wrap_at_done", sp_wrap, r.wrap);
                end
            end
        end
    end

    task automatic do_txn(input logic o, input int n, input logic [23:0] d, input bit poke);
        int cyc;
        bit got;
        if (!o) model_push(n, d, n, 1'b1);
        else    model_pull(n);
        @(negedge clk);
        start = 1'b1; op = o; count = 2'(n); push_data = d;
        @(posedge clk); #1;
        start = 1'b0;
        check("busy_after_start", busy, 1);
        cyc = 0;
        got = 1'b0;
        while (cyc < 10 && !got) begin
            if (poke && cyc == 1) begin
                // Requests while busy must be ignored.
                start = 1'b1; op = ~o; count = 2'd1;
                sp_load = 1'b1; sp_load_val = 8'h33;
            end
            @(posedge clk); #1;
            start = 1'b0;
            sp_load = 1'b0;
            cyc++;
            got = done;
        end
        check("done_latency", cyc, n);
        @(posedge clk); #1;
        check("idle_after_done", busy, 0);
        check("no_done_in_idle", done, 0);
    endtask

    task automatic load_sp(input logic [7:0] v, input bit with_start);
        @(negedge clk);
        sp_load = 1'b1; sp_load_val = v; start = with_start; op = 1'b0; count = 2'd1;
        @(posedge clk); #1;
        sp_load = 1'b0; start = 1'b0;
        ms = v;
        check("sp_loaded", sp, v);
        check("busy_after_load", busy, 0);
        @(posedge clk); #1;
        check("still_idle_after_load", busy, 0);
    endtask

    function automatic logic [7:0] pick_sp();
        case ($urandom_range(0, 4))
            0: return 8'h00;
            1: return 8'h01;
            2: return 8'hFE;
            3: return 8'hFF;
            default: return 8'($urandom);
        endcase
    endfunction

    initial begin
        for (int j = 0; j < 512; j++) mmem[j] = 8'(j) ^ 8'h5A;
        resetn = 1'b0; start = 1'b0; op = 1'b0; count = 2'd0; push_data = 24'h0;
        sp_load = 1'b0; sp_load_val = 8'h00;
        ms = 8'hFF;
        repeat (3) @(posedge clk);
        @(negedge clk);
        resetn = 1'b1;
        @(posedge clk); #1;
        check("reset_sp", sp, 8'hFF);
        check("reset_busy", busy, 0);
        check("reset_wr_enable", wr_enable, 0);
        check("reset_address", address, 16'h0000);
        check("reset_done", done, 0);
        check("reset_pull_data", pull_data, 24'h0);
        check("reset_sp_wrap", sp_wrap, 0);

        // Directed push then pull of three bytes.
        do_txn(1'b0, 3, 24'h563412, 1'b0);
        check("push3_sp", sp, 8'hFC);
        check("push3_wrap", sp_wrap, 0);
        do_txn(1'b1, 3, 24'h0, 1'b0);
        check("pull3_data", pull_data, 24'h123456);
        check("pull3_sp", sp, 8'hFF);

        // Push across the bottom of the page sets sp_wrap; next start clears it.
        load_sp(8'h01, 1'b0);
        do_txn(1'b0, 3, 24'hCCBBAA, 1'b0);
        check("wrap_sp", sp, 8'hFE);
        check("wrap_flag", sp_wrap, 1);
        do_txn(1'b0, 1, 24'h000077, 1'b1);
        check("wrap_cleared", sp_wrap, 0);

        // Illegal requests.
        @(negedge clk);
        start = 1'b1; count = 2'd0;
        @(posedge clk); #1;
        start = 1'b0;
        check("count0_busy", busy, 0);
        repeat (3) @(posedge clk); #1;
        check("count0_busy_later", busy, 0);
        load_sp(8'h80, 1'b1);

        // Randomised traffic.
        for (int t = 0; t < 40; t++) begin
            if ($urandom_range(0, 3) == 0) load_sp(pick_sp(), 1'b0);
            do_txn(1'($urandom_range(0, 1)), int'($urandom_range(1, 3)),
                   24'($urandom), ($urandom_range(0, 4) == 0));
        end

        // Reset after the second write of a three-byte push.
        model_push(3, 24'hF3F2F1, 2, 1'b0);
        @(negedge clk);
        start = 1'b1; op = 1'b0; count = 2'd3; push_data = 24'hF3F2F1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        resetn = 1'b0;
        @(posedge clk); #1;
        ms = 8'hFF;
        check("rst_mid_wr_enable", wr_enable, 0);
        check("rst_mid_busy", busy, 0);
        check("rst_mid_sp", sp, 8'hFF);
        check("rst_mid_done", done, 0);
        check("rst_mid_address", address, 16'h0000);
        @(negedge clk);
        resetn = 1'b1;
        repeat (4) @(posedge clk); #1;
        check("post_rst_busy", busy, 0);
        check("writes_drained", wr_q.size(), 0);
        check("results_drained", res_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
